// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender with 2-entry skid FIFO; compressed formats enabled by IMM_RVC_EN
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [3:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    localparam logic [3:0] SEL_I     = 4'd0;
    localparam logic [3:0] SEL_SHAMT = 4'd1;
    localparam logic [3:0] SEL_S     = 4'd2;
    localparam logic [3:0] SEL_U     = 4'd3;
    localparam logic [3:0] SEL_J     = 4'd4;
    localparam logic [3:0] SEL_B     = 4'd5;
    localparam logic [3:0] SEL_Z     = 4'd6;
`ifdef IMM_RVC_EN
    localparam logic [3:0] SEL_CI    = 4'd8;
    localparam logic [3:0] SEL_CJ    = 4'd9;
    localparam logic [3:0] SEL_CB    = 4'd10;
`endif

    // Low opcode bits are only consumed by the compressed formats (and bits 1:0 never).
    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instr[6:0];

    logic [31:0]     ext32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    // Decode the incoming word into a 32-bit value whose bit 31 is the sign, then widen to XLEN.
    always_comb begin
        ext32       = '0;
        dec_illegal = 1'b0;
        case (in_sel)
            SEL_I:     ext32 = {{20{in_instr[31]}}, in_instr[31:20]};
            SEL_SHAMT: ext32 = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
            SEL_S:     ext32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_U:     ext32 = {in_instr[31:12], 12'b0};
            SEL_J:     ext32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0};
            SEL_B:     ext32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0};
            SEL_Z:     ext32 = {27'b0, in_instr[19:15]};
`ifdef IMM_RVC_EN
            SEL_CI:    ext32 = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
            SEL_CJ:    ext32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9],
                                in_instr[6], in_instr[7], in_instr[2], in_instr[11],
                                in_instr[5:3], 1'b0};
            SEL_CB:    ext32 = {{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2],
                                in_instr[11:10], in_instr[4:3], 1'b0};
`endif
            default:   dec_illegal = 1'b1;
        endcase
        // Zero-extended formats never set bit 31, so widening by bit 31 is safe for all of them.
        dec_imm       = {XLEN{ext32[31]}};
        dec_imm[31:0] = ext32;
    end

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  imm_q [2];
    logic [XLEN-1:0]  imm_d [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [TAG_W-1:0] tag_d [2];
    logic             ill_q [2];
    logic             ill_d [2];
    logic             accept;
    logic             retire;

    assign accept = in_valid && in_ready_q;
    assign retire = out_valid_q && out_ready;

    // FIFO next-state: write decoded entry on accept, advance head on retire, flush clears all.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        imm_d    = imm_q;
        tag_d    = tag_q;
        ill_d    = ill_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) begin
                imm_d[wr_ptr_q] = dec_imm;
                tag_d[wr_ptr_q] = in_tag;
                ill_d[wr_ptr_q] = dec_illegal;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (retire) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({accept, retire})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    // State registers; reset clears storage so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                imm_q[k] <= '0;
                tag_q[k] <= '0;
                ill_q[k] <= 1'b0;
            end
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            tag_q       <= tag_d;
            ill_q       <= ill_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = imm_q[rd_ptr_q];
    assign out_tag     = tag_q[rd_ptr_q];
    assign out_illegal = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe at XLEN 32 and 64
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_tag;
    logic [3:0]  in_sel;

    logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;

    imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));

    imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   mcnt;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        longint t;
        t = v <<< (64 - bits);
        return t >>> (64 - bits);
    endfunction

    // Reference: each format built arithmetically from field values, then sign-extended.
    function automatic exp_t ref_model(input logic [31:0] i, input logic [3:0] sel, input logic [31:0] tag);
        exp_t   e;
        longint v  = 0;
        bit     sh = 0;
        bit     il = 0;
        case (sel)
            4'd0: v = sx(longint'(i[31:20]), 12);
            4'd1: sh = 1;
            4'd2: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            4'd3: v = sx(longint'(i[31:12]) * 4096, 32);
            4'd4: v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                         + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
            4'd5: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                         + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
            4'd6: v = longint'(i[19:15]);
`ifdef IMM_RVC_EN
            4'd8: v = sx(longint'(i[12]) * 32 + longint'(i[6:2]), 6);
            4'd9: v = sx(longint'(i[12]) * 2048 + longint'(i[8]) * 1024 + longint'(i[10:9]) * 256
                         + longint'(i[6]) * 128 + longint'(i[7]) * 64 + longint'(i[2]) * 32
                         + longint'(i[11]) * 16 + longint'(i[5:3]) * 2, 12);
            4'd10: v = sx(longint'(i[12]) * 256 + longint'(i[6:5]) * 64 + longint'(i[2]) * 32
                          + longint'(i[11:10]) * 8 + longint'(i[4:3]) * 2, 9);
`endif
            default: il = 1;
        endcase
        e.imm64 = sh ? 64'(i[25:20]) : 64'(v);
        e.imm32 = sh ? 32'(i[24:20]) : v[31:0];
        e.tag   = tag;
        e.ill   = il;
        return e;
    endfunction

    // One stimulus cycle: drive, check handshake outputs against the model count, record accepts.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [3:0] sel,
                         input bit ordy, input bit fl, input bit rst);
        bit acc, ret;
        in_valid  = v;
        in_instr  = ins;
        in_sel    = sel;
        in_tag    = $urandom;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
        chk("in_ready32", 64'(rdy32), 64'(mcnt < 2));
        chk("in_ready64", 64'(rdy64), 64'(mcnt < 2));
        chk("out_valid32", 64'(ov32), 64'(mcnt != 0));
        chk("out_valid64", 64'(ov64), 64'(mcnt != 0));
        if (rst || fl) begin
            q.delete();
            mcnt = 0;
        end else begin
            acc = v && (mcnt < 2);
            ret = (mcnt != 0) && ordy;
            if (acc) q.push_back(ref_model(ins, sel, in_tag));
            mcnt = mcnt + int'(acc) - int'(ret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input logic [31:0] ins, input logic [3:0] sel,
                            input logic [31:0] e32, input logic [63:0] e64, input bit eill);
        cycle(1, ins, sel, 1, 0, 0);
        chk({nm, "_valid"}, 64'(ov32), 64'd1);
        chk({nm, "_imm32"}, 64'(imm32), 64'(e32));
        chk({nm, "_imm64"}, imm64, e64);
        chk({nm, "_ill"}, 64'(ill32), 64'(eill));
        cycle(0, 32'd0, 4'd0, 1, 0, 0);
    endtask

    // Monitor: pop and compare whenever a head entry is retired.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && !flush && ov32 && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_output: got imm %h with no entry expected", imm32);
                end else begin
                    e = q.pop_front();
                    chk("sb_imm32", 64'(imm32), 64'(e.imm32));
                    chk("sb_imm64", imm64, e.imm64);
                    chk("sb_tag32", 64'(tag32), 64'(e.tag));
                    chk("sb_tag64", 64'(tag64), 64'(e.tag));
                    chk("sb_ill32", 64'(ill32), 64'(e.ill));
                    chk("sb_ill64", 64'(ill64), 64'(e.ill));
                end
            end
        end
    end

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_sel = 0; in_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        mcnt = 0;
        cycle(0, 32'd0, 4'd0, 0, 0, 1);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_ill", 64'(ill32), 64'd0);

        directed("i_neg1", 32'hFFF00093, 4'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0);
        directed("b_neg4", 32'hFE000EE3, 4'd5, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 0);
        directed("u_neg", 32'h800000B7, 4'd3, 32'h80000000, 64'hFFFFFFFF80000000, 0);
        directed("shamt63", 32'h03F00013, 4'd1, 32'h0000001F, 64'h000000000000003F, 0);
        directed("z_31", 32'h000F8073, 4'd6, 32'h0000001F, 64'h000000000000001F, 0);
`ifdef IMM_RVC_EN
        directed("cj_neg2", 32'h0000BFFD, 4'd9, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 0);
`else
        directed("cj_off", 32'h0000BFFD, 4'd9, 32'h0, 64'h0, 1);
`endif
        directed("sel7", 32'hFFFFFFFF, 4'd7, 32'h0, 64'h0, 1);

        // Backpressure: third entry held upstream until space frees.
        cycle(1, $urandom, 4'd0, 0, 0, 0);
        cycle(1, $urandom, 4'd2, 0, 0, 0);
        cycle(1, 32'h12345678, 4'd4, 0, 0, 0);
        chk("bp_full", 64'(rdy32), 64'd0);
        cycle(1, 32'h12345678, 4'd4, 1, 0, 0);
        cycle(1, 32'h12345678, 4'd4, 1, 0, 0);
        repeat (3) cycle(0, 32'd0, 4'd0, 1, 0, 0);

        // Flush while full with a new entry offered.
        cycle(1, $urandom, 4'd0, 0, 0, 0);
        cycle(1, $urandom, 4'd5, 0, 0, 0);
        cycle(1, $urandom, 4'd3, 0, 1, 0);
        chk("flush_valid", 64'(ov32), 64'd0);
        chk("flush_ready", 64'(rdy32), 64'd1);
        repeat (3) cycle(0, 32'd0, 4'd0, 1, 0, 0);

        // Reset while full.
        cycle(1, 32'hFFFFFFFF, 4'd0, 0, 0, 0);
        cycle(1, 32'hFFFFFFFF, 4'd3, 0, 0, 0);
        cycle(1, 32'hFFFFFFFF, 4'd4, 1, 1, 1);
        chk("rst2_valid", 64'(ov64), 64'd0);
        chk("rst2_ready", 64'(rdy64), 64'd1);
        chk("rst2_imm64", imm64, 64'd0);
        chk("rst2_tag64", 64'(tag64), 64'd0);
        chk("rst2_ill64", 64'(ill64), 64'd0);

        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 0);
        end
        repeat (4) cycle(0, 32'd0, 4'd0, 1, 0, 0);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL accept only 32 or 64.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag carried with each instruction.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port flush  input  1  discards all buffered entries.
REQ-006 Port in_valid  input  1  upstream entry valid.
REQ-007 Port in_ready  output  1  block can accept an entry.
REQ-008 Port in_instr  input  32  raw instruction word.
REQ-009 Port in_sel  input  4  format select: 0 I, 1 SHAMT, 2 S, 3 U, 4 J, 5 B, 6 Z (CSR zimm), 8 CI, 9 CJ, 10 CB; 7 and 11-15 reserved.
REQ-010 Port in_tag  input  TAG_W  sideband data, passed through unchanged.
REQ-011 Port out_valid  output  1  head entry valid.
REQ-012 Port out_ready  input  1  downstream accepts the head entry.
REQ-013 Port out_imm  output  XLEN  extended immediate.
REQ-014 Port out_tag  output  TAG_W  tag of the head entry.
REQ-015 Port out_illegal  output  1  head entry used a reserved or disabled in_sel code.

Function
REQ-016 Immediate formats SHALL be as follows.
- I: sign-extended instr[31:20].
- S: sign-extended {instr[31:25], instr[11:7]}.
- U: sign-extended {instr[31:12], 12'b0}.
- J: sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- B: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-017 SHAMT SHALL zero-extend instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64; upper bits SHALL be 0, never X.
REQ-018 Z SHALL zero-extend instr[19:15].
REQ-019 Reserved in_sel codes SHALL produce out_imm=0 and out_illegal=1; all other codes SHALL produce out_illegal=0.
REQ-020 Extension SHALL be computed on acceptance and stored; out_imm SHALL be a register output with no combinational path from in_instr.
REQ-021 Storage SHALL be a 2-entry FIFO (skid buffer); an entry is accepted when in_valid&&in_ready, and the head is retired when out_valid&&out_ready.
REQ-022 in_ready SHALL equal (count<2) and SHALL be registered; it SHALL NOT depend combinationally on out_ready.
REQ-023 Latency: an entry accepted into an empty buffer SHALL assert out_valid on the next cycle.
REQ-024 Simultaneous accept and retire SHALL leave count unchanged, and entries SHALL be delivered in order.
REQ-025 When count=2, in_valid SHALL be ignored and no entry lost; the head and its outputs SHALL hold stable while out_valid&&!out_ready.
REQ-026 Read and write pointers SHALL be 1-bit and wrap modulo 2.
REQ-027 flush SHALL set count=0 and pointers=0 on the next edge; a same-cycle accept or retire SHALL be discarded; in_ready=1 on the following cycle.

Reset
REQ-028 On reset the block SHALL set count=0, pointers=0, out_valid=0, in_ready=1, out_imm=0, out_tag=0 and out_illegal=0.
REQ-029 reset SHALL override flush and handshakes, including mid-transfer with count=2.

Configuration
REQ-030 Macro IMM_RVC_EN SHALL control the compressed formats.
REQ-031 With IMM_RVC_EN defined, codes 8-10 SHALL be decoded as follows.
- CI: sign-extended {instr[12], instr[6:2]}.
- CJ: imm[11]=i12, [10]=i8, [9:8]=i10:9, [7]=i6, [6]=i7, [5]=i2, [4]=i11, [3:1]=i5:3, [0]=0; sign-extended from bit 11.
- CB: imm[8]=i12, [7:6]=i6:5, [5]=i2, [4:3]=i11:10, [2:1]=i4:3, [0]=0; sign-extended from bit 8.
REQ-032 Without IMM_RVC_EN, codes 8-10 SHALL be treated as reserved per REQ-019, and no RVC decode logic SHALL be synthesised.

Verification
REQ-033 XLEN=32: sel=I, instr=0xFFF00093 -> out_imm=0xFFFFFFFF, out_illegal=0, one cycle after accept.
REQ-034 XLEN=32: sel=B, instr=0xFE000EE3 -> 0xFFFFFFFC. XLEN=64: sel=U, instr=0x800000B7 -> 0xFFFFFFFF80000000. XLEN=64: sel=SHAMT, instr[25:20]=63 -> 0x3F.
REQ-035 Backpressure: out_ready=0 with three back-to-back in_valid -> two entries accepted, in_ready=0, third held upstream; out_ready=1 -> the three entries emerge in order, no loss or duplication.
REQ-036 Flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed entries never appear.
REQ-037 IMM_RVC_EN defined: sel=CJ, instr=0x0000BFFD -> 0xFFFFFFFE. Undefined: same stimulus -> out_imm=0, out_illegal=1. Either build: sel=7 -> out_illegal=1.
REQ-038 Assert reset while count=2 -> next cycle all outputs at the REQ-028 values.
